// File: rtl/cmux2_dec2_flopenr_pkg.sv
// Shared constants for the swap-mux / decoder / enabled-register primitive bundle.
// No state, no latency, no flow control.
package cmux2_dec2_flopenr_pkg;
  localparam int WIDTH_DEF      = 8;
  localparam int CMUX_WIDTH_DEF = 32;
  localparam int DEC_IN_W       = 2;
  localparam int DEC_OUT_W      = 4;
  localparam logic FLOP_RST_BIT = 1'b0;

  function automatic logic [DEC_OUT_W-1:0] dec_onehot(input logic [DEC_IN_W-1:0] a);
    dec_onehot    = '0;
    dec_onehot[a] = 1'b1;
  endfunction
endpackage

// File: rtl/cmux2.sv
// Crossed 2-way mux: cm_s swaps which input feeds each output.
// Combinational, zero latency; no backpressure.
module cmux2 #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0] d0,
  input  logic [WIDTH-1:0] d1,
  input  logic             s,
  output logic [WIDTH-1:0] y0,
  output logic [WIDTH-1:0] y1
);
  assign y0 = s ? d1 : d0;
  assign y1 = s ? d0 : d1;
endmodule

// File: rtl/dec2.sv
// 2-to-4 one-hot decoder.
// Combinational, zero latency; no backpressure.
module dec2
  import cmux2_dec2_flopenr_pkg::*;
(
  input  logic [DEC_IN_W-1:0]  a,
  output logic [DEC_OUT_W-1:0] y
);
  assign y = dec_onehot(a);
endmodule

// File: rtl/flopenr.sv
// Enabled register with synchronous active-high reset (reset beats enable).
// One-cycle latency; holds value when en is low.
module flopenr
  import cmux2_dec2_flopenr_pkg::*;
#(
  parameter int WIDTH = WIDTH_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);
  logic [WIDTH-1:0] r_q;

  always_ff @(posedge clk) begin
    if (reset)   r_q <= {WIDTH{FLOP_RST_BIT}};
    else if (en) r_q <= d;
  end

  assign q = r_q;
endmodule

// File: rtl/cmux2_dec2_flopenr.sv
// Wrapper exposing cmux2, dec2 and flopenr; PRIMS_CHECK_EN adds simulation-only X/one-hot checks.
// Mux/decoder are zero-latency, register is one cycle; no backpressure.
module cmux2_dec2_flopenr
  import cmux2_dec2_flopenr_pkg::*;
#(
  parameter int WIDTH      = WIDTH_DEF,
  parameter int CMUX_WIDTH = CMUX_WIDTH_DEF
) (
  input  logic                  ph1,
  input  logic                  ph2,
  input  logic                  reset,
  input  logic                  en,
  input  logic [WIDTH-1:0]      d,
  output logic [WIDTH-1:0]      q,
  input  logic [CMUX_WIDTH-1:0] cm_d0,
  input  logic [CMUX_WIDTH-1:0] cm_d1,
  input  logic                  cm_s,
  output logic [CMUX_WIDTH-1:0] cm_y0,
  output logic [CMUX_WIDTH-1:0] cm_y1,
  input  logic [DEC_IN_W-1:0]   dec_a,
  output logic [DEC_OUT_W-1:0]  dec_y
);
  // ph2 exists only so this wrapper drops into two-phase netlists unchanged.
  logic w_ph2_unused;
  assign w_ph2_unused = ph2;

  cmux2 #(.WIDTH(CMUX_WIDTH)) u_cmux2 (
    .d0 (cm_d0),
    .d1 (cm_d1),
    .s  (cm_s),
    .y0 (cm_y0),
    .y1 (cm_y1)
  );

  dec2 u_dec2 (
    .a (dec_a),
    .y (dec_y)
  );

  flopenr #(.WIDTH(WIDTH)) u_flopenr (
    .clk   (ph1),
    .reset (reset),
    .en    (en),
    .d     (d),
    .q     (q)
  );

`ifdef PRIMS_CHECK_EN
  always @(posedge ph1) begin
    if (reset === 1'b0) begin
      if ($isunknown(cm_s) || $isunknown(dec_a))
        $error("prims: X/Z on cm_s or dec_a out of reset");
      if ($isunknown(en))
        $error("prims: X/Z on en at ph1 edge out of reset");
    end
    if (!$isunknown(dec_a) && !$onehot(dec_y))
      $error("prims: dec_y not one-hot (%b)", dec_y);
  end
`else
`endif
endmodule

// File: tb/tb_cmux2_dec2_flopenr.sv
// Directed self-checking bench for the primitive bundle at default widths.
module tb_cmux2_dec2_flopenr;
  logic        ph1 = 1'b0;
  logic        ph2 = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic [7:0]  d = '0;
  logic [7:0]  q;
  logic [31:0] cm_d0 = '0;
  logic [31:0] cm_d1 = '0;
  logic        cm_s = 1'b0;
  logic [31:0] cm_y0;
  logic [31:0] cm_y1;
  logic [1:0]  dec_a = '0;
  logic [3:0]  dec_y;

  int checks = 0;
  int errors = 0;

  cmux2_dec2_flopenr dut (
    .ph1   (ph1),
    .ph2   (ph2),
    .reset (reset),
    .en    (en),
    .d     (d),
    .q     (q),
    .cm_d0 (cm_d0),
    .cm_d1 (cm_d1),
    .cm_s  (cm_s),
    .cm_y0 (cm_y0),
    .cm_y1 (cm_y1),
    .dec_a (dec_a),
    .dec_y (dec_y)
  );

  initial forever #5 ph1 = ~ph1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic tick();
    @(posedge ph1);
    #1;
  endtask

  initial begin
    logic [3:0] exp_dec;

    // swap mux
    cm_d0 = 32'hAAAA5555; cm_d1 = 32'h12345678; cm_s = 1'b0;
    #1;
    chk("cm_y0_s0", cm_y0, 32'hAAAA5555);
    chk("cm_y1_s0", cm_y1, 32'h12345678);
    cm_s = 1'b1;
    #1;
    chk("cm_y0_s1", cm_y0, 32'h12345678);
    chk("cm_y1_s1", cm_y1, 32'hAAAA5555);
    cm_d0 = 32'h0000FFFF; cm_d1 = 32'hFFFF0000; cm_s = 1'b0;
    #1;
    chk("cm_y0_p2", cm_y0, 32'h0000FFFF);
    chk("cm_y1_p2", cm_y1, 32'hFFFF0000);

    // decoder sweep
    for (int i = 0; i < 4; i++) begin
      dec_a = 2'(i);
      exp_dec = 4'b0001 << i;
      #1;
      chk($sformatf("dec_y_a%0d", i), {28'd0, dec_y}, {28'd0, exp_dec});
    end

    // reset priority over enable
    reset = 1'b1; en = 1'b1; d = 8'hA5;
    tick();
    chk("q_reset_prio", {24'd0, q}, 32'h00);

    // load then hold
    reset = 1'b0; en = 1'b1; d = 8'h3C;
    tick();
    chk("q_load_3c", {24'd0, q}, 32'h3C);
    en = 1'b0; d = 8'hFF;
    for (int i = 0; i < 3; i++) begin
      tick();
      chk($sformatf("q_hold_%0d", i), {24'd0, q}, 32'h3C);
    end

    // reset mid-operation discards the same-cycle load
    reset = 1'b1; en = 1'b1; d = 8'h77;
    tick();
    chk("q_mid_reset", {24'd0, q}, 32'h00);
    reset = 1'b0;
    tick();
    chk("q_release_load", {24'd0, q}, 32'h77);

    // ph2 activity between edges must not disturb the register
    en = 1'b0; d = 8'h11;
    for (int i = 0; i < 3; i++) begin
      #1 ph2 = 1'b1;
      #2 ph2 = 1'b0;
      #1 ph2 = 1'b1;
      chk($sformatf("q_ph2_mid_%0d", i), {24'd0, q}, 32'h77);
      tick();
      ph2 = 1'b0;
      chk($sformatf("q_ph2_edge_%0d", i), {24'd0, q}, 32'h77);
    end

    // reset clears even with enable low
    reset = 1'b1; en = 1'b0;
    tick();
    chk("q_reset_en0", {24'd0, q}, 32'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
